// File: rtl/fp_norm_round.sv
// Post-multiply normalize/round stage: turns a raw 48-bit significand product
// into an IEEE-754 single with round-to-nearest-even, specials and status flags.
module fp_norm_round #(
    parameter int EXP_W   = 10,
    parameter int MAX_LSH = 47
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inexact
);

    localparam int XW = EXP_W + 1;
    localparam int CW = $clog2(MAX_LSH + 1);

    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_OVF  = XW'(255);
    localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_MAX  = CW'(MAX_LSH);
    localparam logic [31:0]          QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_sign;
    logic                  r_zero;
    logic                  r_inf;
    logic                  r_nan;
    logic signed [XW-1:0]  r_exp;
    logic [47:0]           r_mant;
    logic [CW-1:0]         r_cnt;
    logic                  r_sticky;
    logic                  r_force_unf;

    logic                  w_sign_nxt;
    logic                  w_zero_nxt;
    logic                  w_inf_nxt;
    logic                  w_nan_nxt;
    logic signed [XW-1:0]  w_exp_nxt;
    logic [47:0]           w_mant_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_sticky_nxt;
    logic                  w_force_unf_nxt;

    logic                  r_valid;
    logic                  r_in_ready;
    logic [31:0]           r_res;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_inexact;

    logic [31:0]           w_res_nxt;
    logic                  w_ovf_nxt;
    logic                  w_unf_nxt;
    logic                  w_inexact_nxt;

    logic                  w_capture;
    logic                  w_handshake;
    logic                  w_is_zero;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_lsb;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_round_up;
    logic [23:0]           w_frac_sum;
    logic signed [XW-1:0]  w_carry_ext;
    logic signed [XW-1:0]  w_exp_rnd;

    // Round-to-nearest-even increment decision.
    function automatic logic f_round_up(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    function automatic logic [31:0] f_signed_inf(input logic sign);
        return {sign, 8'hFF, 23'h00_0000};
    endfunction

    function automatic logic [31:0] f_signed_zero(input logic sign);
        return {sign, 31'h0000_0000};
    endfunction

    assign w_capture   = in_valid && r_in_ready;
    assign w_handshake = r_valid && out_ready;
    assign w_is_zero   = r_zero || (r_mant == 48'h0000_0000_0000);
    assign w_cnt_inc   = r_cnt + CNT_ONE;

    // Bit 46 is the hidden bit once normalized; everything below bit 22 folds into sticky.
    assign w_lsb       = r_mant[23];
    assign w_guard     = r_mant[22];
    assign w_sticky    = (|r_mant[21:0]) | r_sticky;
    assign w_round_up  = f_round_up(w_lsb, w_guard, w_sticky);
    assign w_frac_sum  = {1'b0, r_mant[45:23]} + {23'h00_0000, w_round_up};
    assign w_carry_ext = {{(XW-1){1'b0}}, w_frac_sum[23]};
    assign w_exp_rnd   = r_exp + w_carry_ext;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_nan || r_inf || w_is_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                if (r_mant[47] || r_mant[46]) begin
                    w_state_nxt = ST_ROUND;
                end else if (w_cnt_inc == CNT_MAX) begin
                    w_state_nxt = ST_ROUND;
                end else begin
                    w_state_nxt = ST_NORM;
                end
            end
            ST_ROUND: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_handshake) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture and iterative normalization datapath.
    always_comb begin
        w_sign_nxt      = r_sign;
        w_zero_nxt      = r_zero;
        w_inf_nxt       = r_inf;
        w_nan_nxt       = r_nan;
        w_exp_nxt       = r_exp;
        w_mant_nxt      = r_mant;
        w_cnt_nxt       = r_cnt;
        w_sticky_nxt    = r_sticky;
        w_force_unf_nxt = r_force_unf;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_sign_nxt      = in_sign;
                    w_zero_nxt      = in_zero;
                    w_inf_nxt       = in_inf;
                    w_nan_nxt       = in_nan;
                    w_exp_nxt       = {in_exp[EXP_W-1], in_exp};
                    w_mant_nxt      = in_mant;
                    w_cnt_nxt       = {CW{1'b0}};
                    w_sticky_nxt    = 1'b0;
                    w_force_unf_nxt = 1'b0;
                end else begin
                    w_mant_nxt      = r_mant;
                end
            end
            ST_NORM: begin
                if (r_mant[47]) begin
                    w_mant_nxt   = {1'b0, r_mant[47:1]};
                    w_sticky_nxt = r_sticky | r_mant[0];
                    w_exp_nxt    = r_exp + EXP_ONE;
                end else if (r_mant[46]) begin
                    w_mant_nxt   = r_mant;
                end else begin
                    w_mant_nxt      = {r_mant[46:0], 1'b0};
                    w_exp_nxt       = r_exp - EXP_ONE;
                    w_cnt_nxt       = w_cnt_inc;
                    w_force_unf_nxt = (w_cnt_inc == CNT_MAX);
                end
            end
            default: begin
                w_mant_nxt = r_mant;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_inf       <= 1'b0;
            r_nan       <= 1'b0;
            r_exp       <= EXP_ZERO;
            r_mant      <= 48'h0000_0000_0000;
            r_cnt       <= {CW{1'b0}};
            r_sticky    <= 1'b0;
            r_force_unf <= 1'b0;
        end else begin
            r_sign      <= w_sign_nxt;
            r_zero      <= w_zero_nxt;
            r_inf       <= w_inf_nxt;
            r_nan       <= w_nan_nxt;
            r_exp       <= w_exp_nxt;
            r_mant      <= w_mant_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sticky    <= w_sticky_nxt;
            r_force_unf <= w_force_unf_nxt;
        end
    end

    // Result and flag formation; held untouched while waiting in DONE.
    always_comb begin
        w_res_nxt     = r_res;
        w_ovf_nxt     = r_ovf;
        w_unf_nxt     = r_unf;
        w_inexact_nxt = r_inexact;
        case (r_state)
            ST_LOAD: begin
                w_ovf_nxt     = 1'b0;
                w_unf_nxt     = 1'b0;
                w_inexact_nxt = 1'b0;
                if (r_nan) begin
                    w_res_nxt = QNAN;
                end else if (r_inf) begin
                    w_res_nxt = f_signed_inf(r_sign);
                end else if (w_is_zero) begin
                    w_res_nxt = f_signed_zero(r_sign);
                end else begin
                    w_res_nxt = r_res;
                end
            end
            ST_ROUND: begin
                w_inexact_nxt = w_guard | w_sticky;
                if (w_exp_rnd >= EXP_OVF) begin
                    w_res_nxt = f_signed_inf(r_sign);
                    w_ovf_nxt = 1'b1;
                    w_unf_nxt = 1'b0;
                end else if ((w_exp_rnd <= EXP_ZERO) || r_force_unf) begin
                    w_res_nxt = f_signed_zero(r_sign);
                    w_ovf_nxt = 1'b0;
                    w_unf_nxt = 1'b1;
                end else begin
                    w_res_nxt = {r_sign, w_exp_rnd[7:0], w_frac_sum[22:0]};
                    w_ovf_nxt = 1'b0;
                    w_unf_nxt = 1'b0;
                end
            end
            default: begin
                w_res_nxt = r_res;
            end
        endcase
    end

    // Output registers; handshake flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
            r_res      <= 32'h0000_0000;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inexact  <= 1'b0;
        end else begin
            r_valid    <= (w_state_nxt == ST_DONE);
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_res      <= w_res_nxt;
            r_ovf      <= w_ovf_nxt;
            r_unf      <= w_unf_nxt;
            r_inexact  <= w_inexact_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_valid;
    assign out_result  = r_res;
    assign out_ovf     = r_ovf;
    assign out_unf     = r_unf;
    assign out_inexact = r_inexact;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed cases from known IEEE values
// plus randomized products checked against an arithmetic rounding model.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = 10'd0;
    logic [47:0] in_mant = 48'd0;
    logic        in_zero = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_nan = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        int          cap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    logic prev_v = 1'b0;

    fp_norm_round #(.EXP_W(10), .MAX_LSH(47)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf),
        .out_unf(out_unf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: value-level normalize to 24 significant bits, RNE, range check.
    function automatic exp_t model(input logic s, input logic [9:0] ex, input logic [47:0] m,
                                   input logic z, input logic i, input logic n);
        exp_t        r;
        int          p;
        int          e;
        int          sh;
        logic [63:0] kept;
        logic [63:0] rem;
        logic [63:0] half;
        logic        rup;
        r.fl = 3'b000; r.lat = 1; r.cap = 0; r.res = 32'h0;
        if (n) r.res = 32'h7FC0_0000;
        else if (i) r.res = {s, 8'hFF, 23'h0};
        else if (z || m == 48'd0) r.res = {s, 31'h0};
        else begin
            p = 0;
            for (int b = 0; b < 48; b++) if (m[b]) p = b;
            e = int'($signed(ex)) + p - 46;
            r.lat = (p >= 46) ? 3 : 3 + (46 - p);
            if (p >= 23) begin
                sh   = p - 23;
                kept = 64'(m) >> sh;
                rem  = 64'(m) & ((64'd1 << sh) - 64'd1);
                half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
                rup  = (sh > 0) && ((rem > half) || (rem == half && kept[0]));
                r.fl[0] = (rem != 64'd0);
            end else begin
                kept = 64'(m) << (23 - p);
                rup  = 1'b0;
            end
            kept = kept + {63'd0, rup};
            if (kept[24]) begin
                kept = kept >> 1;
                e++;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'h0}; r.fl[2] = 1'b1;
            end else if (e <= 0) begin
                r.res = {s, 31'h0}; r.fl[1] = 1'b1;
            end else begin
                r.res = {s, e[7:0], kept[22:0]};
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input exp_t e, input logic s, input logic [9:0] ex, input logic [47:0] m,
                        input logic z, input logic i, input logic n);
        exp_t ee;
        int   g = 0;
        ee = e;
        while (!in_ready && g < 500) begin
            tick();
            g++;
        end
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            in_sign = s; in_exp = ex; in_mant = m;
            in_zero = z; in_inf = i; in_nan = n;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            ee.cap = cyc;
            sb.push_back(ee);
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (sb.size() != 0 && g < 3000) begin
            tick();
            g++;
        end
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic run_dir(input logic s, input logic [9:0] ex, input logic [47:0] m,
                           input logic z, input logic i, input logic n,
                           input logic [31:0] res, input logic [2:0] fl, input int lat);
        exp_t e;
        e.res = res; e.fl = fl; e.lat = lat; e.cap = 0;
        send(e, s, ex, m, z, i, n);
        wait_done();
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_valid", {31'd0, out_valid}, 32'd0);
                else check("latency", cyc - sb[0].cap, sb[0].lat);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_result, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    check("result", out_result, e.res);
                    check("flags", {29'd0, out_ovf, out_unf, out_inexact}, {29'd0, e.fl});
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        s, z, i, n;
        logic [9:0]  ex;
        logic [47:0] m;
        logic [63:0] tmp;
        int          k;
        int          g;
        exp_t        e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_flags", {29'd0, out_ovf, out_unf, out_inexact}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_dir(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000, 3);
        run_dir(1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001, 3);
        run_dir(1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001, 3);
        run_dir(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001, 3);
        run_dir(1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b100, 3);
        run_dir(1'b0, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b010, 3);
        run_dir(1'b1, 10'd300, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 3'b100, 3);
        run_dir(1'b0, 10'h3FB, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b010, 3);
        run_dir(1'b0, 10'd127, 48'h0000_0080_0000, 1'b0, 1'b0, 1'b0, 32'h3400_0000, 3'b000, 26);
        run_dir(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000, 3'b000, 1);
        run_dir(1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b000, 1);
        run_dir(1'b1, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3'b000, 1);
        run_dir(1'b1, 10'd127, 48'h0000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b000, 1);

        // Backpressure: result must hold and a new request must be refused.
        out_ready = 1'b0;
        e.res = 32'h4010_0000; e.fl = 3'b000; e.lat = 3; e.cap = 0;
        send(e, 1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("bp_hold", out_result, 32'h4010_0000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            in_nan   = (c == 1);
            in_valid = (c == 1);
            tick();
        end
        in_valid = 1'b0;
        in_nan = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_idle", {31'd0, in_ready}, 32'd1);
        repeat (4) tick();
        check("bp_no_capture", {31'd0, out_valid}, 32'd0);
        check("bp_queue", sb.size(), 32'd0);

        // Abort a long left-shift sequence with reset.
        e = model(1'b0, 10'd127, 48'h0000_0080_0000, 1'b0, 1'b0, 1'b0);
        send(e, 1'b0, 10'd127, 48'h0000_0080_0000, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run_dir(1'b1, 10'd128, 48'h6000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hC040_0000, 3'b000, 3);

        // Randomized products with random downstream stalls.
        rand_rdy = 1'b1;
        for (int t = 0; t < 200; t++) begin
            s   = 1'($urandom_range(0, 1));
            k   = $urandom_range(0, 99);
            n   = (k < 4);
            i   = (k >= 4 && k < 8);
            z   = (k >= 8 && k < 12);
            tmp = {$urandom(), $urandom()};
            m   = tmp[47:0];
            case ($urandom_range(0, 4))
                0: m = m >> $urandom_range(2, 47);
                1: m[47] = 1'b1;
                2: m[47:46] = 2'b01;
                3: begin
                    m[47:46] = 2'b01;
                    m[22:0]  = 23'h40_0000;
                end
                default: m = ($urandom_range(0, 9) == 0) ? 48'd0 : m;
            endcase
            if ($urandom_range(0, 9) == 0) ex = tmp[57:48];
            else ex = 10'($urandom_range(0, 290));
            e = model(s, ex, m, z, i, n);
            send(e, s, ex, m, z, i, n);
        end
        wait_done();
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-multiply normalize/round stage. Sits directly downstream of the floating-point multiplier's raw datapath.
- Consumes the raw product: sign, signed biased exponent sum and 48-bit significand product.
- Produces an IEEE-754 single-precision result with round-to-nearest-even, special-value handling and status flags.
- Multi-cycle iterative normalizer with a valid/ready handshake on both sides, so the multiplier core can be pipelined against it.

Parameters:
- EXP_W, 10: width of the signed, two's-complement biased exponent input (e1+e2-127 range).
- MAX_LSH, 47: maximum left-shift iterations before forcing underflow.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- in_sign  in  1  product sign (s1^s2).
- in_exp  in  EXP_W  signed biased exponent sum, already minus bias.
- in_mant  in  48  unsigned 24x24 product including hidden bits.
- in_zero  in  1  either operand is zero.
- in_inf  in  1  either operand is infinity.
- in_nan  in  1  either operand is NaN, or the case is inf*0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  {sign, exp[7:0], frac[22:0]}.
- out_ovf  out  1  overflow to infinity.
- out_unf  out  1  underflow flushed to zero.
- out_inexact  out  1  guard or sticky bit nonzero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; out_result=0; all flags=0.
  - Internal mant/exp/counter registers cleared.
  - in_ready=1 after release.
- Capture: on an edge with in_valid&&in_ready, latch all inputs and the shift counter (0).
- Next state after capture (priority nan > inf > zero > normal):
  - nan: DONE with out_result=0x7FC00000; flags 0.
  - inf: DONE with {in_sign, 0xFF, 0}; flags 0.
  - in_zero, or in_mant==0: DONE with {in_sign, 31'b0}; flags 0.
  - otherwise: NORM.
- NORM, one decision per cycle:
  - mant[47]=1: mant>>=1 (shifted-out bit ORed into sticky), exp+=1, go ROUND.
  - mant[46]=1: go ROUND.
  - else: mant<<=1, exp-=1, counter+=1. If counter reaches MAX_LSH, go ROUND with the underflow path forced.
- ROUND, one cycle:
  - lsb=mant[23], guard=mant[22], sticky=|mant[21:0] | shifted sticky.
  - Increment frac=mant[45:23] iff guard&&(sticky||lsb).
  - Carry out of frac (all ones +1): frac=0, exp+=1.
  - inexact=guard|sticky.
  - exp>=255 (signed): result {sign, 0xFF, 0}, ovf=1.
  - exp<=0 or forced underflow: result {sign, 31'b0}, unf=1 (no subnormals).
  - else: {sign, exp[7:0], frac}.
  - Go DONE.
- DONE:
  - out_valid=1; out_result and flags held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go IDLE.
  - in_ready=0 in every state except IDLE; no overlap, no bypass of DONE.
- Latency from the capture edge k:
  - Specials: out_valid high after edge k+1.
  - Normalized product (bit47 or bit46 set): out_valid high after edge k+3 (NORM k+1, ROUND k+2, DONE k+3).
  - Each left shift adds 1 cycle.
- in_valid while not IDLE is ignored; upstream must hold its data.
- Reset mid-operation aborts immediately with no partial output. in_ready=1 on the first edge after release.
- Exponent arithmetic is done at EXP_W+1 bits to avoid wrap. Negative in_exp is legal and yields underflow.

Test Plan:
- Normal case: in_exp=127, in_mant=0x900000000000 (1.5*1.5), out_ready=1 -> out_result=0x40100000, inexact=0, out_valid 3 cycles after capture.
- Rounding, even (no increment): in_exp=127, in_mant=0x400000400000 -> 0x3F800000, inexact=1.
- Rounding, increment: in_mant=0x400000C00000 -> 0x3F800002, inexact=1.
- Carry-out: in_mant=0x7FFFFFC00000 -> 0x40000000.
- Range limits:
  - Overflow: in_exp=254, in_mant=0x800000000000 -> 0x7F800000, ovf=1.
  - Underflow: in_exp=0, in_mant=0x400000000000 -> 0x00000000, unf=1.
  - Sign check: in_sign=1, in_exp=300 -> 0xFF800000, ovf=1.
- Specials:
  - in_nan=1 -> 0x7FC00000 after 1 cycle.
  - in_inf=1, in_sign=1 -> 0xFF800000.
  - in_zero=1, in_sign=1 -> 0x80000000.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid -> out_result stable, in_ready=0, a new in_valid pulse is not captured. Raise out_ready -> one-cycle handshake, then IDLE.
- Reset mid-NORM: in_mant=0x000000800000 (long left shift), drop rst_n during NORM -> out_valid=0 immediately, in_ready=1 after release, next transaction correct.
